pkt_rr_arbiter: RTL
===================

PKT_RR_ARBITER -- requirements
Module: pkt_rr_arbiter

Interface
REQ-001: Parameter DATA_WIDTH, default 64: width of one data word per queue.
REQ-002: Parameter CTRL_WIDTH, default DATA_WIDTH/8: width of one ctrl word per queue.
REQ-003: Parameter NUM_QUEUES, default 4: number of requester queues; 4 is the only supported value.
REQ-004: clk  input  1  single clock; all state changes on its rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: in_data  input  NUM_QUEUES*DATA_WIDTH  fallthrough-FIFO dout per queue; queue i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007: in_ctrl  input  NUM_QUEUES*CTRL_WIDTH  fallthrough-FIFO ctrl per queue, packed as in_data.
REQ-008: in_empty  input  NUM_QUEUES  per-queue FIFO empty flag.
REQ-009: in_rd_en  output  NUM_QUEUES  per-queue read strobe; combinational, at most one bit high.
REQ-010: out_data  output  DATA_WIDTH  registered output word.
REQ-011: out_ctrl  output  CTRL_WIDTH  registered output ctrl.
REQ-012: out_wr  output  1  registered write strobe for out_data/out_ctrl.
REQ-013: out_rdy  input  1  downstream may accept at least 2 more words.

Function
REQ-014: The block SHALL have FSM states IDLE, HDR, PKT, plus registers cur_q[1:0] and last_q[1:0].
REQ-015: In IDLE, if any in_empty bit is 0, the block SHALL load cur_q with the first non-empty queue searching (last_q+1), (last_q+2), ... modulo 4 and SHALL enter HDR next cycle; no read occurs in the grant cycle.
REQ-016: In HDR or PKT, in_rd_en[cur_q] SHALL equal out_rdy & ~in_empty[cur_q]; all other in_rd_en bits SHALL be 0; in IDLE all in_rd_en bits SHALL be 0.
REQ-017: A read cycle SHALL register in_data/in_ctrl of cur_q into out_data/out_ctrl and SHALL set out_wr=1 on the next edge (latency 1 cycle); otherwise out_wr SHALL be 0 and out_data/out_ctrl SHALL hold.
REQ-018: In HDR, a read word with ctrl==0 SHALL move the FSM to PKT; a read word with ctrl!=0 (module header) SHALL stay in HDR.
REQ-019: In PKT, a read word with ctrl!=0 SHALL be end-of-packet: FSM to IDLE, last_q<=cur_q.
REQ-020: Grant SHALL be held for the whole packet; in_empty[cur_q]=1 or out_rdy=0 mid-packet SHALL stall without changing state or grant.
REQ-021: Requests arriving on other queues mid-packet SHALL NOT preempt; they are considered only on return to IDLE.
REQ-022: Minimum gap between packets SHALL be one idle (grant) cycle.

Reset
REQ-023: On reset assertion, asynchronously: FSM=IDLE, cur_q=0, last_q=3 (queue 0 wins first), out_wr=0, out_data=0, out_ctrl=0, in_rd_en=0.
REQ-024: Reset mid-packet SHALL abandon the packet; no partial resumption after release; upstream FIFOs are reset by their owner.

Configuration
REQ-025: With ARB_PKT_STATS_EN defined, the block SHALL add output pkt_count (NUM_QUEUES*16 bits), one 16-bit counter per queue incremented on each end-of-packet read of that queue, wrapping 0xFFFF->0x0000, cleared by reset.
REQ-026: Without ARB_PKT_STATS_EN, port pkt_count and counters SHALL not exist; all other behaviour identical.

Verification
REQ-027: Reset, queue 2 holds pkt {ctrl FF hdr, 00, 00, ctrl 01 eop}, out_rdy=1 -> grant cycle, then 4 consecutive out_wr words identical to input, FSM IDLE after eop, last_q=2.
REQ-028: All 4 queues each hold one 3-word pkt after reset -> output order q0,q1,q2,q3, no interleaving, one idle cycle between packets.
REQ-029: q1 mid-packet, out_rdy dropped 3 cycles -> in_rd_en=0 for those 3 cycles, out_wr=0 one cycle later for 3 cycles, no word lost or duplicated.
REQ-030: q0 granted, in_empty[0]=1 for 5 cycles mid-packet while q3 non-empty -> grant stays q0, q3 served only after q0 eop.
REQ-031: reset asserted mid-packet between clk edges -> outputs zero immediately, FSM IDLE; after release q0 has priority.
REQ-032: ARB_PKT_STATS_EN defined, 65537 pkts through q1 -> pkt_count[31:16]=1; undefined build compiles without pkt_count.

Source files
------------

// File: rtl/pkt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pkt_rr_arbiter
//
// Round-robin packet arbiter. It merges four fallthrough FIFOs into one
// registered output stream. A queue keeps the grant for a whole packet. The
// next grant is searched starting from the queue after the one that last
// finished a packet.
//
// Packet framing, as seen on the ctrl field:
//   - In HDR, words with ctrl != 0 are module headers. The first word with
//     ctrl == 0 starts the payload (PKT).
//   - In PKT, the first word with ctrl != 0 ends the packet.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    NUM_QUEUES x DATA_WIDTH; FIFO dout of queue i is at
//              [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ctrl    NUM_QUEUES x CTRL_WIDTH; packed the same way as in_data
//   in_empty   per-queue FIFO empty flag
//   in_rd_en   per-queue read strobe; combinational, at most one bit high
//   out_data   registered output word
//   out_ctrl   registered output ctrl
//   out_wr     registered write strobe for out_data/out_ctrl
//   out_rdy    downstream can take at least two more words
//   pkt_count  (only with ARB_PKT_STATS_EN) one 16-bit end-of-packet
//              counter per queue; queue i is at [i*16 +: 16]
//
// Build option:
//   ARB_PKT_STATS_EN  when defined, adds the pkt_count output and its counters.
// -----------------------------------------------------------------------------
module pkt_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_empty,
    output logic [NUM_QUEUES-1:0]            in_rd_en,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
`ifdef ARB_PKT_STATS_EN
    output logic [NUM_QUEUES*16-1:0]         pkt_count,
`endif
    input  logic                             out_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PKT  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [1:0]              cur_q_r;
    logic [1:0]              last_q_r;

    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic [CTRL_WIDTH-1:0]   sel_ctrl_s;
    logic                    sel_empty_s;
    logic                    rd_s;
    logic                    ctrl_zero_s;
    logic                    eop_s;
    logic                    any_req_s;
    logic [1:0]              next_q_s;

    // Round-robin search. Candidates are last+1, last+2, last+3, last.
    // The loop runs from the lowest priority up, so the nearest non-empty
    // queue is the one left in the result.
    function automatic logic [1:0] rr_pick(input logic [1:0]            last,
                                           input logic [NUM_QUEUES-1:0] empty);
        logic [1:0] cand;
        logic [1:0] pick;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + k[1:0];
            if (!empty[cand]) begin
                pick = cand;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Mux the granted queue's FIFO head. Generate the read strobe and the
    // next-grant choice.
    always_comb begin
        sel_data_s  = in_data[cur_q_r*DATA_WIDTH +: DATA_WIDTH];
        sel_ctrl_s  = in_ctrl[cur_q_r*CTRL_WIDTH +: CTRL_WIDTH];
        sel_empty_s = in_empty[cur_q_r];
        ctrl_zero_s = (sel_ctrl_s == {CTRL_WIDTH{1'b0}});
        if (state_r != ST_IDLE) begin
            rd_s = out_rdy & ~sel_empty_s;
        end else begin
            rd_s = 1'b0;
        end
        in_rd_en          = {NUM_QUEUES{1'b0}};
        in_rd_en[cur_q_r] = rd_s;
        eop_s     = (state_r == ST_PKT) & rd_s & ~ctrl_zero_s;
        any_req_s = ~(&in_empty);
        next_q_s  = rr_pick(last_q_r, in_empty);
    end

    // Packet FSM, grant registers and the registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cur_q_r  <= 2'd0;
            last_q_r <= 2'd3;
            out_wr   <= 1'b0;
            out_data <= {DATA_WIDTH{1'b0}};
            out_ctrl <= {CTRL_WIDTH{1'b0}};
        end else begin
            out_wr <= rd_s;
            if (rd_s) begin
                out_data <= sel_data_s;
                out_ctrl <= sel_ctrl_s;
            end
            case (state_r)
                // The grant cycle performs no read. The gap it leaves between
                // packets is the single idle cycle on the output.
                ST_IDLE: begin
                    if (any_req_s) begin
                        cur_q_r <= next_q_s;
                        state_r <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (rd_s && ctrl_zero_s) begin
                        state_r <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (eop_s) begin
                        state_r  <= ST_IDLE;
                        last_q_r <= cur_q_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PKT_STATS_EN
    logic [15:0] pkt_cnt_r [NUM_QUEUES];

    // Per-queue end-of-packet counters. They wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                pkt_cnt_r[i] <= 16'd0;
            end
        end else if (eop_s) begin
            pkt_cnt_r[cur_q_r] <= pkt_cnt_r[cur_q_r] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt
        assign pkt_count[g*16 +: 16] = pkt_cnt_r[g];
    end
`endif

endmodule
